// File: rtl/stream_prefetch_buf_if.sv
// AXI3 read-address / read-data channel bundle between the prefetch buffer and external memory.
interface stream_prefetch_buf_if;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [5:0]  m_axi_arid;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic [1:0]  m_axi_rresp;

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    output m_axi_rready,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp
  );

  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
    input  m_axi_rready,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, m_axi_rresp
  );
endinterface

// File: rtl/stream_prefetch_buf.sv
// Two-line prefetch buffer feeding decode_stream bytes from external memory over AXI3 reads.
// Hits answer combinationally; misses and next-line prefetches fetch a whole INCR burst.
module stream_prefetch_buf #(
  parameter int unsigned LINE_BEATS = 16,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] stream_base,
  input  logic [31:0] stream_len,
  input  logic [31:0] stream_mem_addr_out,
  input  logic        stream_mem_rd,
  output logic [7:0]  stream_mem_data_in,
  output logic        stream_mem_valid,
  output logic        stream_mem_end,
  output logic        axi_err,
  stream_prefetch_buf_if.master m_axi
);

  localparam int unsigned LINE_BYTES = LINE_BEATS * 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned BEAT_W     = $clog2(LINE_BEATS);
  localparam int unsigned TAG_W      = 32 - OFF_W;

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t             state, state_nxt;
  logic [1:0]         slot_vld;
  logic [TAG_W-1:0]   slot_tag [2];
  logic [63:0]        slot_data [2][LINE_BEATS];
  logic               lru;
  logic               fill_slot;
  logic               discard;
  logic [BEAT_W-1:0]  beat_cnt;

  logic [TAG_W-1:0]   req_tag;
  logic [BEAT_W-1:0]  req_beat;
  logic [2:0]         req_byte;
  logic               in_range;
  logic [1:0]         hit_vec;
  logic               rd_hit;
  logic               hit_slot;
  logic [63:0]        sel_beat;
  logic [TAG_W-1:0]   nxt_tag;
  logic [32:0]        nxt_start;
  logic               nxt_resident;
  logic               prefetch_ok;
  logic               start_fetch;
  logic               fetch_slot;
  logic [TAG_W-1:0]   fetch_tag;
  logic               r_beat;

  always_comb begin
    req_tag   = stream_mem_addr_out[31:OFF_W];
    req_beat  = stream_mem_addr_out[OFF_W-1:3];
    req_byte  = stream_mem_addr_out[2:0];
    in_range  = stream_mem_addr_out < stream_len;
    hit_vec[0] = slot_vld[0] && (slot_tag[0] == req_tag);
    hit_vec[1] = slot_vld[1] && (slot_tag[1] == req_tag);
    rd_hit    = stream_mem_rd && in_range && (|hit_vec);
    hit_slot  = hit_vec[1];
    sel_beat  = slot_data[hit_slot][req_beat];

    stream_mem_valid   = rd_hit;
    stream_mem_end     = stream_mem_rd && !in_range;
    stream_mem_data_in = rd_hit ? sel_beat[{req_byte, 3'b000} +: 8] : '0;

    // 33-bit start so a next line past 4 GiB can never compare below stream_len
    nxt_tag      = slot_tag[hit_slot] + 1'b1;
    nxt_start    = {1'b0, slot_tag[hit_slot], {OFF_W{1'b0}}} + 33'(LINE_BYTES);
    nxt_resident = (slot_vld[0] && (slot_tag[0] == nxt_tag)) ||
                   (slot_vld[1] && (slot_tag[1] == nxt_tag));
    prefetch_ok  = (nxt_start < {1'b0, stream_len}) && !nxt_resident;
  end

  always_comb begin
    state_nxt           = state;
    start_fetch         = 1'b0;
    fetch_slot          = lru;
    fetch_tag           = req_tag;
    m_axi.m_axi_arvalid = 1'b0;
    m_axi.m_axi_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush) begin
          if (stream_mem_rd && in_range && !(|hit_vec)) begin
            start_fetch = 1'b1;
          end else if (rd_hit && prefetch_ok) begin
            start_fetch = 1'b1;
            fetch_slot  = !hit_slot;
            fetch_tag   = nxt_tag;
          end
        end
        if (start_fetch) state_nxt = AR;
      end
      AR: begin
        m_axi.m_axi_arvalid = 1'b1;
        if (m_axi.m_axi_arready) state_nxt = R;
      end
      R: begin
        m_axi.m_axi_rready = 1'b1;
        if (m_axi.m_axi_rvalid && m_axi.m_axi_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign r_beat = (state == R) && m_axi.m_axi_rvalid;

  assign m_axi.m_axi_araddr  = stream_base + {slot_tag[fill_slot], {OFF_W{1'b0}}};
  assign m_axi.m_axi_arlen   = 4'(LINE_BEATS - 1);
  assign m_axi.m_axi_arsize  = 3'd3;
  assign m_axi.m_axi_arburst = 2'b01;
  assign m_axi.m_axi_arid    = 6'(AXI_ID);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot_vld    <= '0;
      slot_tag[0] <= '0;
      slot_tag[1] <= '0;
      lru         <= 1'b0;
      fill_slot   <= 1'b0;
      discard     <= 1'b0;
      beat_cnt    <= '0;
      axi_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (rd_hit) lru <= !hit_slot;
      if (start_fetch) begin
        slot_vld[fetch_slot] <= 1'b0;
        slot_tag[fetch_slot] <= fetch_tag;
        fill_slot            <= fetch_slot;
        beat_cnt             <= '0;
        discard              <= 1'b0;
      end
      if (r_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (m_axi.m_axi_rresp != 2'b00) axi_err <= 1'b1;
        if (m_axi.m_axi_rlast && !discard) slot_vld[fill_slot] <= 1'b1;
      end
      // Placed last so a flush overrides a same-cycle rlast or error beat.
      if (flush) begin
        slot_vld <= '0;
        axi_err  <= 1'b0;
        if (state != IDLE) discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_beat) slot_data[fill_slot][beat_cnt] <= m_axi.m_axi_rdata;
  end

endmodule
